dmem_boot_loader: RTL and testbench

//  Bus initiator on the core's data-memory write port (MemWrite/DataAdr/WriteData):

---
 rtl/dmem_boot_loader.sv | 123 ++++++++++++
 tb/tb_dmem_boot_loader.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_boot_loader.sv
// dmem_boot_loader
//   Bus initiator on the core's data-memory write port. Packs an incoming byte
//   stream into 32-bit little-endian words and writes NUM_WORDS consecutive
//   words to dmem starting at BASE_ADDR. The RV32I core is held in reset
//   through cpu_hold until the whole image has been written.
//
// Parameters
//   BASE_ADDR  byte address of the first word (4-byte aligned)
//   NUM_WORDS  words per load (>= 1)
//
// Ports
//   clk         system clock, rising edge
//   reset       asynchronous active-high reset
//   start       1-cycle pulse, begins a load from IDLE or DONE
//   byte_valid  byte_data is valid
//   byte_data   next image byte, little-endian within a word
//   byte_ready  byte accepted when byte_valid && byte_ready (COLLECT only)
//   MemWrite    dmem write strobe, one cycle per word
//   DataAdr     dmem byte address, valid while MemWrite=1
//   WriteData   dmem write data, valid while MemWrite=1
//   busy        load in progress (COLLECT or WRITE)
//   done        image fully written
//   cpu_hold    1 keeps the core in reset; 0 only in DONE
//   checksum    mod-2^32 sum of the words written in the current load
module dmem_boot_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int unsigned NUM_WORDS = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        MemWrite,
  output logic [31:0] DataAdr,
  output logic [31:0] WriteData,
  output logic        busy,
  output logic        done,
  output logic        cpu_hold,
  output logic [31:0] checksum
);

  localparam int unsigned IW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WRITE   = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t        state;
  logic [1:0]    byte_cnt;
  logic [IW-1:0] word_idx;
  logic [31:0]   word;

  assign byte_ready = (state == COLLECT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      byte_cnt  <= '0;
      word_idx  <= '0;
      word      <= '0;
      MemWrite  <= 1'b0;
      DataAdr   <= '0;
      WriteData <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cpu_hold  <= 1'b1;
      checksum  <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state    <= COLLECT;
            byte_cnt <= '0;
            word_idx <= '0;
            checksum <= '0;
            busy     <= 1'b1;
            done     <= 1'b0;
            cpu_hold <= 1'b1;
          end
        end

        COLLECT: begin
          if (byte_valid) begin
            word[{byte_cnt, 3'b000} +: 8] <= byte_data;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              // Bus outputs are loaded on the 4th handshake so they are
              // already stable during the single WRITE cycle; the top byte
              // comes straight from the input since word is not yet updated.
              state     <= WRITE;
              MemWrite  <= 1'b1;
              DataAdr   <= BASE_ADDR + (32'(word_idx) << 2);
              WriteData <= {byte_data, word[23:0]};
            end
          end
        end

        WRITE: begin
          MemWrite <= 1'b0;
          checksum <= checksum + word;
          if (word_idx == LAST_IDX) begin
            state    <= DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            cpu_hold <= 1'b0;
          end else begin
            word_idx <= word_idx + IW'(1);
            state    <= COLLECT;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_boot_loader.sv
// Testbench for dmem_boot_loader (NUM_WORDS=2, BASE_ADDR=0). Stimulus pushes
// expected (address, data) writes into a queue; a monitor pops and compares
// on every MemWrite cycle.
module tb_dmem_boot_loader;

  logic        clk;
  logic        reset;
  logic        start;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        MemWrite;
  logic [31:0] DataAdr;
  logic [31:0] WriteData;
  logic        busy;
  logic        done;
  logic        cpu_hold;
  logic [31:0] checksum;

  dmem_boot_loader #(.BASE_ADDR(32'h0), .NUM_WORDS(2)) dut (
    .clk(clk), .reset(reset), .start(start),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .MemWrite(MemWrite), .DataAdr(DataAdr), .WriteData(WriteData),
    .busy(busy), .done(done), .cpu_hold(cpu_hold), .checksum(checksum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [63:0] exp_q[$];
  logic [7:0]  img [0:7];
  logic        prev_mw = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every MemWrite cycle must match the head of the scoreboard.
  always @(negedge clk) begin
    if (MemWrite === 1'b1) begin
      check("byte_ready_in_write", {31'b0, byte_ready}, 32'h0);
      check("memwrite_single_cycle", {31'b0, prev_mw}, 32'h0);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL spurious_write: got adr 0x%08h data 0x%08h expected none", DataAdr, WriteData);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        check("write_adr", DataAdr, e[63:32]);
        check("write_data", WriteData, e[31:0]);
      end
    end
    prev_mw = (MemWrite === 1'b1);
  end

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  // Sends img[0..n-1]; with gaps set, some cycles drop byte_valid. byte_valid
  // stays high while waiting, so WRITE cycles see a pending byte.
  task automatic send_image(input int n, input bit gaps);
    int i = 0;
    int cyc = 0;
    int g = 0;
    while (i < n && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (gaps && (g % 3 == 1)) begin
        byte_valid = 1'b0;
        g++;
      end else begin
        byte_valid = 1'b1;
        byte_data  = img[i];
        #1;
        if (byte_ready) begin
          i++;
          g++;
        end
      end
    end
    @(negedge clk);
    byte_valid = 1'b0;
    check("bytes_sent", i, n);
  endtask

  task automatic wait_done();
    int cyc = 0;
    while (done !== 1'b1 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("done_reached", {31'b0, done}, 32'h1);
  endtask

  task automatic load_t2_image();
    img[0] = 8'h13; img[1] = 8'h00; img[2] = 8'h50; img[3] = 8'h00;
    img[4] = 8'h93; img[5] = 8'h02; img[6] = 8'hC0; img[7] = 8'h00;
  endtask

  task automatic expect_t2();
    exp_q.push_back({32'h0, 32'h00500013});
    exp_q.push_back({32'h4, 32'h00C00293});
  endtask

  task automatic check_final(input logic [31:0] sum);
    check("done", {31'b0, done}, 32'h1);
    check("cpu_hold_done", {31'b0, cpu_hold}, 32'h0);
    check("busy_done", {31'b0, busy}, 32'h0);
    check("checksum", checksum, sum);
    check("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Bytes offered in IDLE are not taken.
    @(negedge clk); byte_valid = 1'b1; byte_data = 8'hAA;
    #1 check("byte_ready_idle", {31'b0, byte_ready}, 32'h0);
    check("cpu_hold_idle", {31'b0, cpu_hold}, 32'h1);
    @(negedge clk); byte_valid = 1'b0;

    // T2: back-to-back image.
    load_t2_image();
    expect_t2();
    pulse_start();
    check("busy_collect", {31'b0, busy}, 32'h1);
    send_image(8, 1'b0);
    wait_done();
    check_final(32'h011002A6);

    // T1: asynchronous reset mid-cycle.
    @(posedge clk); #3 reset = 1'b1;
    #1;
    check("rst_memwrite", {31'b0, MemWrite}, 32'h0);
    check("rst_adr", DataAdr, 32'h0);
    check("rst_wdata", WriteData, 32'h0);
    check("rst_busy", {31'b0, busy}, 32'h0);
    check("rst_done", {31'b0, done}, 32'h0);
    check("rst_cpu_hold", {31'b0, cpu_hold}, 32'h1);
    check("rst_checksum", checksum, 32'h0);
    check("rst_byte_ready", {31'b0, byte_ready}, 32'h0);
    @(negedge clk); reset = 1'b0;

    // T3: gaps and byte_valid held through WRITE.
    expect_t2();
    pulse_start();
    send_image(8, 1'b1);
    wait_done();
    check_final(32'h011002A6);

    // T4: reset after two bytes of word 0, then full reload.
    pulse_start();
    send_image(2, 1'b0);
    @(posedge clk); #2 reset = 1'b1;
    #1 check("rst_mid_cpu_hold", {31'b0, cpu_hold}, 32'h1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    expect_t2();
    pulse_start();
    send_image(8, 1'b0);
    wait_done();
    check_final(32'h011002A6);

    // T5: start during COLLECT is ignored.
    expect_t2();
    pulse_start();
    send_image(3, 1'b0);
    pulse_start();
    check("busy_after_ignored_start", {31'b0, busy}, 32'h1);
    img[0] = img[3]; img[1] = img[4]; img[2] = img[5]; img[3] = img[6]; img[4] = img[7];
    send_image(5, 1'b0);
    wait_done();
    check_final(32'h011002A6);

    // T5/T6: restart from DONE, then a wrapping checksum.
    pulse_start();
    check("restart_done", {31'b0, done}, 32'h0);
    check("restart_cpu_hold", {31'b0, cpu_hold}, 32'h1);
    check("restart_checksum", checksum, 32'h0);
    img[0] = 8'hFF; img[1] = 8'hFF; img[2] = 8'hFF; img[3] = 8'hFF;
    img[4] = 8'h02; img[5] = 8'h00; img[6] = 8'h00; img[7] = 8'h00;
    exp_q.push_back({32'h0, 32'hFFFFFFFF});
    exp_q.push_back({32'h4, 32'h00000002});
    send_image(8, 1'b0);
    wait_done();
    check_final(32'h00000001);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
